// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed program image from a byte source
// into instruction memory, then releases the core from reset.
// Stream: count N (2 bytes, big-endian), N words (4 bytes each, MSB first),
// then one checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (running XOR of count and data
// bytes, checked against a trailing byte before the load is declared done).
//
// state  | meaning
// -------+---------------------------------------------------------------
// LEN_HI | waiting for the high byte of the word count
// LEN_LO | waiting for the low byte; range-checks the count
// DATA   | assembling words, one imem write per 4 bytes
// CHECK  | waiting for the checksum byte (checksum build only)
// DONE   | image loaded, core released one cycle later (terminal)
// ERR    | bad count or checksum, core held in reset (terminal)

module prog_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CHECK;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t      state, state_nxt;
    logic        xfer;
    logic [7:0]  len_hi;
    logic [15:0] len_full;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic        last_byte;
    logic        last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign xfer      = byte_valid & byte_ready;
    assign len_full  = {len_hi, byte_data};
    assign last_byte = (byte_cnt == 2'd3);
    assign last_word = (word_idx == word_cnt - 16'd1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= LEN_HI;
        else        state <= state_nxt;
    end

    // Next-state logic; a zero count skips straight to the tail state
    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI: if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0)    state_nxt = TAIL;
                    else if (len_full > MAX_W) state_nxt = ERR;
                    else                       state_nxt = DATA;
                end
            end
            DATA: if (xfer && last_byte && last_word) state_nxt = TAIL;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: if (xfer) state_nxt = (byte_data == csum) ? DONE : ERR;
`endif
            default: state_nxt = state;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        byte_ready = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA, CHECK: byte_ready = 1'b1;
            DONE:                        done       = 1'b1;
            ERR:                         err        = 1'b1;
            default:                     byte_ready = 1'b0;
        endcase
    end

    // Datapath: count capture, word assembly, write strobe, core reset release
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_hi     <= 8'd0;
            word_cnt   <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            asm_q      <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
        end else begin
            imem_we    <= 1'b0;
            // registered so release trails done by one cycle and the final strobe
            core_reset <= (state != DONE);
            if (xfer) begin
                case (state)
                    LEN_HI: len_hi   <= byte_data;
                    LEN_LO: word_cnt <= len_full;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_q    <= {asm_q[15:0], byte_data};
                        if (last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_BASE + {14'd0, word_idx, 2'b00};
                            imem_wdata <= {asm_q, byte_data};
                            word_idx   <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running XOR over count and data bytes
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum <= 8'd0;
        end else if (xfer && (state == LEN_HI || state == LEN_LO || state == DATA)) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

endmodule
